// File: rtl/shift_pkg.sv
// Shared definitions for the shift issue stage:
// opcodes, func codes, instruction fields, buffer states.
package shift_pkg;

  localparam logic [3:0] OP_SLL = 4'h1;
  localparam logic [3:0] OP_SRL = 4'h2;
  localparam logic [3:0] OP_SRA = 4'h3;

  localparam logic [3:0] FN_PASS = 4'b0000;
  localparam logic [3:0] FN_SLL  = 4'b0001;
  localparam logic [3:0] FN_SRL  = 4'b0010;
  localparam logic [3:0] FN_SRA  = 4'b0011;

  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RS_LSB = 4;
  localparam int SH_LSB = 0;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  function automatic logic [3:0] decode_func(
    input logic [3:0] op
  );
    logic [3:0] fn;
    fn = FN_PASS;
    unique case (1'b1)
      op == OP_SLL: fn = FN_SLL;
      op == OP_SRL: fn = FN_SRL;
      op == OP_SRA: fn = FN_SRA;
      default:      fn = FN_PASS;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/shift_skid_buf.sv
// Two-entry FIFO skid buffer; head entry drives
// the output straight from flops, ready is registered.
module shift_skid_buf
  import shift_pkg::*;
#(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [1:0]   st_q, st_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         rdy_q, rdy_d;
  logic         push, pop;

  assign push        = in_valid_i && rdy_q;
  assign pop         = out_valid_o && out_ready_i;
  assign out_valid_o = (st_q != ST_EMPTY);
  assign out_data_o  = head_q;
  assign in_ready_o  = rdy_q;

  // Next occupancy and entry contents from push/pop.
  always_comb begin
    st_d   = st_q;
    head_d = head_q;
    tail_d = tail_q;
    case (st_q)
      ST_EMPTY: begin
        if (push) begin
          head_d = in_data_i;
          st_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_d = in_data_i;
        end else if (push) begin
          tail_d = in_data_i;
          st_d   = ST_FULL;
        end else if (pop) begin
          st_d   = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          head_d = tail_q;
          st_d   = ST_ONE;
        end
      end
      default: st_d = ST_EMPTY;
    endcase
    rdy_d = (st_d != ST_FULL);
  end

  // State, entries and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_EMPTY;
      head_q <= '0;
      tail_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      st_q   <= st_d;
      head_q <= head_d;
      tail_q <= tail_d;
      rdy_q  <= rdy_d;
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Decode-to-execute issue stage feeding shift_unit:
// decode, writeback bypass, skid buffer, stall counter.
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int DW   = 16,
  parameter int RW   = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [15:0]     id_instr,
  input  logic [DW-1:0]   id_rs_data,
  input  logic            wb_valid,
  input  logic [RW-1:0]   wb_rd,
  input  logic [DW-1:0]   wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [DW-1:0]   ex_in,
  output logic [3:0]      ex_func,
  output logic [3:0]      ex_shamt,
  output logic [RW-1:0]   ex_rd,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int W = DW + 4 + 4 + RW;

  logic [3:0]      op;
  logic [RW-1:0]   rs;
  logic [RW-1:0]   rd;
  logic [3:0]      shamt;
  logic [3:0]      func;
  logic [DW-1:0]   operand;
  logic [W-1:0]    pkt;
  logic [W-1:0]    head;
  logic [CNTW-1:0] stall_q, stall_d;
  logic            stall;

  assign op    = id_instr[OP_LSB +: 4];
  assign rd    = id_instr[RD_LSB +: RW];
  assign rs    = id_instr[RS_LSB +: RW];
  assign shamt = id_instr[SH_LSB +: 4];
  assign func  = decode_func(op);

  // Writeback bypass, sampled only in the accept cycle.
  always_comb begin
    operand = id_rs_data;
    if (wb_valid && (wb_rd == rs)) begin
      operand = wb_data;
    end
  end

  assign pkt = {operand, func, shamt, rd};

  shift_skid_buf #(
    .W (W)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (id_valid),
    .in_ready_o  (id_ready),
    .in_data_i   (pkt),
    .out_valid_o (ex_valid),
    .out_ready_i (ex_ready),
    .out_data_o  (head)
  );

  assign {ex_in, ex_func, ex_shamt, ex_rd} = head;

  // Saturating count of cycles decode is held off.
  always_comb begin
    stall   = id_valid && !id_ready;
    stall_d = stall_q;
    if (stall && !(&stall_q)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage against
// a queue-based reference model of the issue stage.
module tb_shift_issue_stage;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  f;
    logic [3:0]  s;
    logic [3:0]  r;
  } op_t;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [15:0] id_rs_data;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [15:0] ex_in;
  logic [3:0]  ex_func;
  logic [3:0]  ex_shamt;
  logic [3:0]  ex_rd;
  logic [3:0]  stall_cnt;

  int checks;
  int errors;

  op_t mq[$];
  int  stall_m;
  bit  last_acc;

  shift_issue_stage #(
    .DW   (16),
    .RW   (4),
    .CNTW (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_rs_data (id_rs_data),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_in      (ex_in),
    .ex_func    (ex_func),
    .ex_shamt   (ex_shamt),
    .ex_rd      (ex_rd),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic op_t mdl_op();
    op_t o;
    int  opc;
    opc = int'(id_instr[15:12]);
    o.f = (opc >= 1 && opc <= 3) ? id_instr[15:12] : 4'h0;
    o.s = id_instr[3:0];
    o.r = id_instr[11:8];
    if (wb_valid && wb_rd == id_instr[7:4]) o.d = wb_data;
    else o.d = id_rs_data;
    return o;
  endfunction

  // One clock: model decides from current inputs, then both advance.
  task automatic cycle();
    bit  acc;
    bit  ret;
    op_t o;
    acc = id_valid && (mq.size() < 2);
    ret = (mq.size() > 0) && ex_ready;
    if (id_valid && mq.size() >= 2 && stall_m < 15) stall_m++;
    o = mdl_op();
    @(posedge clk);
    if (ret) void'(mq.pop_front());
    if (acc) mq.push_back(o);
    last_acc = acc;
    #1;
  endtask

  function automatic op_t dut_head();
    return {ex_in, ex_func, ex_shamt, ex_rd};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    id_valid = 0; id_instr = 0; id_rs_data = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; ex_ready = 0;
    mq.delete(); stall_m = 0;
    #12;
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ex_valid got %b exp 0", ex_valid);
    end
    checks++;
    if (id_ready !== 1'b1) begin
      errors++; $display("FAIL reset_id_ready got %b exp 1", id_ready);
    end
    checks++;
    if (stall_cnt !== 4'h0) begin
      errors++; $display("FAIL reset_stall got %h exp 0", stall_cnt);
    end
    checks++;
    if (dut_head() !== '0) begin
      errors++; $display("FAIL reset_ex_bus got %h exp 0", dut_head());
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_decode();
    logic [15:0] sh;
    ex_ready = 1; wb_valid = 0;
    id_valid = 1; id_instr = 16'h3524; id_rs_data = 16'h8000;
    cycle();
    id_valid = 0;
    checks++;
    if (ex_valid !== 1'b1) begin
      errors++; $display("FAIL dec_valid got %b exp 1", ex_valid);
    end
    checks++;
    if ({ex_func, ex_shamt, ex_rd} !== {4'b0011, 4'd4, 4'd5}) begin
      errors++;
      $display("FAIL dec_fields got %h/%h/%h exp 3/4/5",
               ex_func, ex_shamt, ex_rd);
    end
    checks++;
    if (ex_in !== 16'h8000) begin
      errors++; $display("FAIL dec_in got %h exp 8000", ex_in);
    end
    sh = $signed(ex_in) >>> ex_shamt;
    checks++;
    if (sh !== 16'hF800) begin
      errors++; $display("FAIL dec_sra got %h exp f800", sh);
    end
    cycle();
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++; $display("FAIL dec_drain got %b exp 0", ex_valid);
    end
  endtask

  task automatic test_bypass();
    ex_ready = 1;
    id_valid = 1; id_instr = 16'h1721; id_rs_data = 16'h0001;
    wb_valid = 1; wb_rd = 4'd2; wb_data = 16'h00F0;
    cycle();
    checks++;
    if (ex_in !== 16'h00F0) begin
      errors++; $display("FAIL byp_hit got %h exp 00f0", ex_in);
    end
    wb_rd = 4'd3;
    cycle();
    checks++;
    if (ex_in !== 16'h0001) begin
      errors++; $display("FAIL byp_miss got %h exp 0001", ex_in);
    end
    id_valid = 0; wb_valid = 0;
    cycle();
  endtask

  task automatic test_backpressure();
    op_t got[$];
    op_t exp_q[3];
    exp_q[0] = {16'h0011, 4'h1, 4'h3, 4'h1};
    exp_q[1] = {16'h8421, 4'h2, 4'h5, 4'h2};
    exp_q[2] = {16'hBEEF, 4'h0, 4'h9, 4'h3};
    ex_ready = 0; wb_valid = 0;
    id_valid = 1; id_instr = 16'h1103; id_rs_data = 16'h0011;
    cycle();
    checks++;
    if (id_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_a got %b exp 1", id_ready);
    end
    id_instr = 16'h2205; id_rs_data = 16'h8421;
    cycle();
    checks++;
    if (id_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready_b got %b exp 0", id_ready);
    end
    id_instr = 16'h7309; id_rs_data = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (id_ready !== 1'b0 || ex_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold got rdy %b vld %b exp 0 1",
                 id_ready, ex_valid);
      end
    end
    checks++;
    if (stall_cnt !== 4'd3) begin
      errors++; $display("FAIL bp_stall got %0d exp 3", stall_cnt);
    end
    ex_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if (ex_valid) got.push_back(dut_head());
      cycle();
      if (last_acc) id_valid = 0;
    end
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL bp_count got %0d exp 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL bp_order[%0d] got %h exp %h",
                   i, got[i], exp_q[i]);
        end
      end
    end
    id_valid = 0;
  endtask

  task automatic test_simultaneous();
    op_t e;
    ex_ready = 1; wb_valid = 0;
    id_valid = 1;
    id_instr = 16'($urandom); id_rs_data = 16'($urandom);
    cycle();
    for (int i = 0; i < 10; i++) begin
      id_instr = 16'($urandom); id_rs_data = 16'($urandom);
      e = mdl_op();
      cycle();
      checks++;
      if (id_ready !== 1'b1 || ex_valid !== 1'b1 || dut_head() !== e) begin
        errors++;
        $display("FAIL sim[%0d] got rdy %b vld %b op %h exp 1 1 %h",
                 i, id_ready, ex_valid, dut_head(), e);
      end
    end
    id_valid = 0;
    cycle();
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++; $display("FAIL sim_drain got %b exp 0", ex_valid);
    end
  endtask

  task automatic test_saturation();
    ex_ready = 0; wb_valid = 0; id_valid = 1;
    for (int i = 0; i < 2 + 21; i++) begin
      id_instr = 16'($urandom); id_rs_data = 16'($urandom);
      cycle();
    end
    checks++;
    if (stall_cnt !== 4'hF) begin
      errors++; $display("FAIL sat_cnt got %h exp f", stall_cnt);
    end
  endtask

  task automatic test_reset_mid();
    checks++;
    if (ex_valid !== 1'b1 || id_ready !== 1'b0) begin
      errors++;
      $display("FAIL rm_pre got vld %b rdy %b exp 1 0", ex_valid, id_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1 || stall_cnt !== 4'h0) begin
      errors++;
      $display("FAIL rm_async got vld %b rdy %b cnt %h exp 0 1 0",
               ex_valid, id_ready, stall_cnt);
    end
    mq.delete(); stall_m = 0;
    id_valid = 0; ex_ready = 1;
    #2 rst_n = 1'b1;
    cycle();
    checks++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_after got vld %b rdy %b exp 0 1", ex_valid, id_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_valid   = ($urandom_range(0, 3) != 0);
      id_instr   = 16'($urandom);
      id_instr[7:4] = 4'($urandom_range(0, 3));
      id_rs_data = 16'($urandom);
      wb_valid   = $urandom_range(0, 1) == 1;
      wb_rd      = 4'($urandom_range(0, 3));
      wb_data    = 16'($urandom);
      ex_ready   = ($urandom_range(0, 2) != 0);
      cycle();
      checks++;
      if (ex_valid !== (mq.size() > 0) ||
          id_ready !== (mq.size() < 2) ||
          stall_cnt !== 4'(stall_m)) begin
        errors++;
        $display("FAIL rnd_ctl[%0d] got v%b r%b c%0d exp v%b r%b c%0d",
                 i, ex_valid, id_ready, stall_cnt,
                 mq.size() > 0, mq.size() < 2, stall_m);
      end
      if (mq.size() > 0) begin
        checks++;
        if (dut_head() !== mq[0]) begin
          errors++;
          $display("FAIL rnd_op[%0d] got %h exp %h", i, dut_head(), mq[0]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_acc = 0;
    test_reset();
    test_decode();
    test_bypass();
    test_backpressure();
    test_simultaneous();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
